// File: rtl/mac_array_pkg.sv
// Shared encodings and configuration-word layout for the MAC array tile.
package mac_array_pkg;

  typedef enum logic [1:0] {
    ModeIdle = 2'b00,
    ModeMul  = 2'b01,
    ModeMac  = 2'b10,
    ModeRsvd = 2'b11
  } mode_e;

  // INIT sits at the bottom of a lane word; the other fields are offsets above ACC_WIDTH.
  localparam int unsigned INIT_LSB   = 0;
  localparam int unsigned MODE_LSB   = 0;
  localparam int unsigned SGN_BIT    = 2;
  localparam int unsigned SAT_BIT    = 3;
  localparam int unsigned CTRL_BITS  = 4;

  function automatic int unsigned lane_conf_w(input int unsigned acc_width);
    return acc_width + CTRL_BITS;
  endfunction

endpackage

// File: rtl/mac_array_lane.sv
// One MAC lane: registered product, accumulator with optional saturation, sticky overflow.
module mac_array_lane
  import mac_array_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           cset,
  input  logic                           v1,
  input  logic                           acc_clr,
  input  logic [IN_WIDTH-1:0]            a,
  input  logic [IN_WIDTH-1:0]            b,
  input  logic [ACC_WIDTH+CTRL_BITS-1:0] conf,
  input  logic [ACC_WIDTH-1:0]           new_init,
  output logic [ACC_WIDTH-1:0]           acc,
  output logic                           overflow
);

  localparam int unsigned PW = 2 * IN_WIDTH;

  logic [ACC_WIDTH-1:0] init;
  mode_e                mode;
  logic                 sgn, sat;

  assign init = conf[INIT_LSB +: ACC_WIDTH];
  assign mode = mode_e'(conf[ACC_WIDTH+MODE_LSB +: 2]);
  assign sgn  = conf[ACC_WIDTH+SGN_BIT];
  assign sat  = conf[ACC_WIDTH+SAT_BIT];

  logic [PW-1:0] a_x, b_x, p_d, p_q;
  logic          clr1_q;

  assign a_x = {{IN_WIDTH{sgn & a[IN_WIDTH-1]}}, a};
  assign b_x = {{IN_WIDTH{sgn & b[IN_WIDTH-1]}}, b};
  assign p_d = a_x * b_x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q    <= '0;
      clr1_q <= 1'b0;
    end else if (en) begin
      p_q    <= p_d;
      clr1_q <= acc_clr;
    end
  end

  logic [ACC_WIDTH-1:0] p_ext, base, mac_res, acc_d, acc_q;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf_s, ovf_u, mac_ovf, ovf_d, ovf_q;

  always_comb begin
    p_ext          = {ACC_WIDTH{sgn & p_q[PW-1]}};
    p_ext[PW-1:0]  = p_q;
  end

  assign base    = clr1_q ? init : acc_q;
  assign sum     = {1'b0, base} + {1'b0, p_ext};
  assign ovf_s   = (base[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
  assign ovf_u   = sum[ACC_WIDTH];
  assign mac_ovf = sgn ? ovf_s : ovf_u;

  always_comb begin
    mac_res = sum[ACC_WIDTH-1:0];
    if (mac_ovf && sat) begin
      if (!sgn)                    mac_res = '1;
      else if (base[ACC_WIDTH-1])  mac_res = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else                         mac_res = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (cset) begin
      acc_d = new_init;
      ovf_d = 1'b0;
    end else if (en && v1) begin
      if (clr1_q) ovf_d = 1'b0;
      case (mode)
        ModeMul: acc_d = p_ext;
        ModeMac: begin
          acc_d = mac_res;
          ovf_d = ovf_d | mac_ovf;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc      = acc_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/mac_array_tile.sv
// NUM_LANES-wide MAC tile with a serial shadow/active configuration chain.
module mac_array_tile
  import mac_array_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           cen,
  input  logic                           cset,
  input  logic                           shift_in,
  output logic                           shift_out,
  output logic                           cset_out,
  input  logic                           in_valid,
  input  logic [NUM_LANES*IN_WIDTH-1:0]  a,
  input  logic [NUM_LANES*IN_WIDTH-1:0]  b,
  input  logic [NUM_LANES-1:0]           acc_clr,
  output logic [NUM_LANES*ACC_WIDTH-1:0] out,
  output logic                           out_valid,
  output logic [NUM_LANES-1:0]           overflow
);

  localparam int unsigned LANE_CONF_W = lane_conf_w(ACC_WIDTH);
  localparam int unsigned CONF_W      = NUM_LANES * LANE_CONF_W;

  logic [CONF_W-1:0] shadow_q, active_q;
  logic              v1_q, out_valid_q, cset_out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q    <= '0;
      active_q    <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      cset_out_q  <= 1'b0;
    end else begin
      if (cen)  shadow_q <= {shadow_q[CONF_W-2:0], shift_in};
      if (cset) active_q <= shadow_q;
      cset_out_q <= cset;
      // A config latch flushes whatever is in flight.
      if (cset) begin
        v1_q        <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= v1_q & en;
        if (en) v1_q <= in_valid;
      end
    end
  end

  assign shift_out = shadow_q[CONF_W-1];
  assign cset_out  = cset_out_q;
  assign out_valid = out_valid_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mac_array_lane #(
      .IN_WIDTH (IN_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .cset    (cset),
      .v1      (v1_q),
      .acc_clr (acc_clr[i]),
      .a       (a[i*IN_WIDTH +: IN_WIDTH]),
      .b       (b[i*IN_WIDTH +: IN_WIDTH]),
      .conf    (active_q[i*LANE_CONF_W +: LANE_CONF_W]),
      .new_init(shadow_q[i*LANE_CONF_W+INIT_LSB +: ACC_WIDTH]),
      .acc     (out[i*ACC_WIDTH +: ACC_WIDTH]),
      .overflow(overflow[i])
    );
  end

endmodule

// File: tb/tb_mac_array_tile.sv
// Scoreboard bench for mac_array_tile: directed beats push expected results, a monitor pops.
module tb_mac_array_tile;

  localparam int CW = 144;

  logic         clk, rst, en, cen, cset, shift_in, shift_out, cset_out, in_valid, out_valid;
  logic [31:0]  a, b;
  logic [3:0]   acc_clr, overflow;
  logic [127:0] out;

  typedef struct packed {
    logic [127:0] out;
    logic [3:0]   ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  mac_array_tile #(
    .NUM_LANES(4),
    .IN_WIDTH (8),
    .ACC_WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cen      (cen),
    .cset     (cset),
    .shift_in (shift_in),
    .shift_out(shift_out),
    .cset_out (cset_out),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .acc_clr  (acc_clr),
    .out      (out),
    .out_valid(out_valid),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] lane_cfg(input logic [31:0] init, input logic [1:0] mode,
                                           input logic sgn, input logic sat);
    return {sat, sgn, mode, init};
  endfunction

  function automatic logic [127:0] pack4(input logic [31:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] av, input logic [31:0] bv, input logic [3:0] clr,
                      input bit push, input logic [127:0] e_out, input logic [3:0] e_ovf);
    exp_t e;
    a = av; b = bv; acc_clr = clr; in_valid = 1'b1;
    if (push) begin
      e.out = e_out;
      e.ovf = e_ovf;
      q.push_back(e);
    end
    tick();
    in_valid = 1'b0; a = '0; b = '0; acc_clr = '0;
  endtask

  task automatic shift_chain(input logic [CW-1:0] pat, input bit chk, input logic [CW-1:0] prev);
    cen = 1'b1;
    for (int j = 0; j < CW; j++) begin
      if (chk) check("shift_out_replay", 128'(shift_out), 128'(prev[CW-1-j]));
      shift_in = pat[CW-1-j];
      tick();
    end
    cen = 1'b0;
    shift_in = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && out_valid) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got out=%h, no result expected", out);
      end else begin
        e = q.pop_front();
        if (out !== e.out || overflow !== e.ovf) begin
          errors++;
          $display("FAIL scoreboard: got out=%h ovf=%b expected out=%h ovf=%b",
                   out, overflow, e.out, e.ovf);
        end
      end
    end
  end

  logic [CW-1:0]  p1, cfg1, cfg2;
  logic [127:0]   init_v;

  initial begin
    rst = 1'b0; en = 1'b1; cen = 1'b0; cset = 1'b0; shift_in = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; acc_clr = '0;
    p1   = {4{36'hC3A5F0E71}};
    cfg1 = {lane_cfg(32'h1234, 2'b00, 1'b0, 1'b1), lane_cfg(32'h7FFFFFF0, 2'b10, 1'b1, 1'b1),
            lane_cfg(32'h0, 2'b01, 1'b1, 1'b0),    lane_cfg(32'd10, 2'b10, 1'b0, 1'b0)};
    cfg2 = {lane_cfg(32'h1234, 2'b00, 1'b0, 1'b1), lane_cfg(32'h7FFFFFF0, 2'b10, 1'b1, 1'b0),
            lane_cfg(32'h0, 2'b01, 1'b1, 1'b0),    lane_cfg(32'd10, 2'b10, 1'b0, 1'b0)};
    init_v = pack4(32'h1234, 32'h7FFFFFF0, 32'h0, 32'd10);

    #3;
    check("reset_out", out, '0);
    check("reset_out_valid", 128'(out_valid), '0);
    check("reset_overflow", 128'(overflow), '0);
    check("reset_shift_out", 128'(shift_out), '0);
    rst = 1'b1;
    tick();

    // Configuration chain: load a scratch pattern, then push the real config through it.
    shift_chain(p1, 1'b0, '0);
    shift_chain(cfg1, 1'b1, p1);
    check("cset_out_idle", 128'(cset_out), '0);
    cset = 1'b1;
    tick();
    cset = 1'b0;
    check("cset_out_pulse", 128'(cset_out), 128'd1);
    check("cset_out_valid", 128'(out_valid), '0);
    check("cset_init", out, init_v);
    check("cset_overflow", 128'(overflow), '0);
    tick();
    check("cset_out_drop", 128'(cset_out), '0);

    // Unsigned MAC lane 0, back-to-back beats.
    beat(32'h3, 32'h4, 4'b0001, 1'b1, pack4(32'h1234, 32'h7FFFFFF0, 0, 32'd22), 4'b0000);
    beat(32'h5, 32'h6, 4'b0000, 1'b1, pack4(32'h1234, 32'h7FFFFFF0, 0, 32'd52), 4'b0000);
    // Signed MUL lane 1.
    beat(32'h0000FF00, 32'h00000200, 4'b0000, 1'b1,
         pack4(32'h1234, 32'h7FFFFFF0, 32'hFFFFFFFE, 32'd52), 4'b0000);
    // Signed saturating MAC lane 2, then overflow stays sticky on a non-clearing beat.
    beat(32'h007F0000, 32'h007F0000, 4'b0100, 1'b1,
         pack4(32'h1234, 32'h7FFFFFFF, 0, 32'd52), 4'b0100);
    beat(32'h0, 32'h0, 4'b0000, 1'b1, pack4(32'h1234, 32'h7FFFFFFF, 0, 32'd52), 4'b0100);
    repeat (3) tick();

    // Reconfigure with lane 2 wrapping instead of saturating.
    shift_chain(cfg2, 1'b1, cfg1);
    cset = 1'b1;
    tick();
    cset = 1'b0;
    check("recfg_init", out, init_v);
    check("recfg_ovf_clear", 128'(overflow), '0);
    beat(32'h007F0000, 32'h007F0000, 4'b0100, 1'b1,
         pack4(32'h1234, 32'h80003EF1, 0, 32'd10), 4'b0100);
    repeat (3) tick();

    // Stall: beat A waits in stage 1 for three en=0 cycles.
    beat(32'h2, 32'h3, 4'b0101, 1'b1, pack4(32'h1234, 32'h7FFFFFF0, 0, 32'd16), 4'b0000);
    en = 1'b0;
    repeat (3) begin
      tick();
      check("stall_out_valid", 128'(out_valid), '0);
      check("stall_out_hold", out, pack4(32'h1234, 32'h80003EF1, 0, 32'd10));
    end
    en = 1'b1;
    tick();
    beat(32'h4, 32'h5, 4'b0000, 1'b1, pack4(32'h1234, 32'h7FFFFFF0, 0, 32'd36), 4'b0000);
    repeat (3) tick();

    // Flush: cset while a beat sits in stage 1.
    beat(32'h7, 32'h7, 4'b0000, 1'b0, '0, '0);
    cset = 1'b1;
    tick();
    cset = 1'b0;
    check("flush_out_valid", 128'(out_valid), '0);
    check("flush_init", out, init_v);
    repeat (3) tick();
    check("flush_hold", out, init_v);

    // Asynchronous reset while out_valid is high.
    beat(32'h1, 32'h1, 4'b0001, 1'b1, pack4(32'h1234, 32'h7FFFFFF0, 0, 32'd11), 4'b0000);
    tick();
    check("pre_reset_valid", 128'(out_valid), 128'd1);
    check("pre_reset_lane3", 128'(out[127:96]), 128'h1234);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_out", out, '0);
    check("async_reset_valid", 128'(out_valid), '0);
    check("async_reset_overflow", 128'(overflow), '0);
    check("async_reset_shift_out", 128'(shift_out), '0);
    tick();
    rst = 1'b1;
    tick();

    check("scoreboard_drained", 128'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end

endmodule
